// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage register: upstream valid/data/ready
// on the *_i/ready_o side and downstream valid/data/ready on the *_o/ready_i side.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic              ready_o;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              ready_i;

    // slave: the stage itself; master: whatever surrounds it
    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o
    );
    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush and saturating back-pressure counter.
// Define PIPE_STAGE_SKID_EN for a registered-ready skid buffer; otherwise a plain stall register.
module pipe_stage_reg #(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipe_stage_reg_if.slave  bus,
    input  logic             flush_i,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] main_reg, main_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic              valid_int, ready_int;
    logic              in_xfer, out_xfer;
`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_reg, skid_next;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output decode
    always_comb begin
        valid_int = (state_reg != ST_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
        // Registered ready: breaks the ready_i -> ready_o timing path
        ready_int = (state_reg != ST_SKID);
`else
        ready_int = bus.ready_i | (state_reg == ST_EMPTY);
`endif
    end

    assign in_xfer     = bus.valid_i & ready_int;
    assign out_xfer    = valid_int & bus.ready_i;
    assign bus.valid_o = valid_int;
    assign bus.ready_o = ready_int;
    assign bus.data_o  = main_reg;
    assign stall_cnt_o = stall_cnt_reg;

    // Next-state logic; flush overrides everything
    always_comb begin
        state_next = state_reg;
        if (flush_i) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_xfer) state_next = ST_FULL;
                end
                ST_FULL: begin
                    if (out_xfer && !in_xfer) begin
                        state_next = ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_xfer && !bus.ready_i) begin
                        state_next = ST_SKID;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_SKID: begin
                    if (bus.ready_i) state_next = ST_FULL;
                end
`endif
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // Payload datapath
    always_comb begin
        main_next = main_reg;
`ifdef PIPE_STAGE_SKID_EN
        skid_next = skid_reg;
`endif
        if (flush_i) begin
            main_next = RST_VAL;
`ifdef PIPE_STAGE_SKID_EN
            skid_next = RST_VAL;
`endif
        end else begin
`ifdef PIPE_STAGE_SKID_EN
            case (state_reg)
                ST_EMPTY: if (in_xfer) main_next = bus.data_i;
                ST_FULL: begin
                    // Downstream stalled: park the new word so data_o stays put
                    if (in_xfer && bus.ready_i)  main_next = bus.data_i;
                    else if (in_xfer)            skid_next = bus.data_i;
                end
                ST_SKID: if (bus.ready_i) main_next = skid_reg;
                default: main_next = main_reg;
            endcase
`else
            // ready_o already folds in ready_i, so any accepted word may overwrite
            if (in_xfer) main_next = bus.data_i;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_reg <= RST_VAL;
`ifdef PIPE_STAGE_SKID_EN
            skid_reg <= RST_VAL;
`endif
        end else begin
            main_reg <= main_next;
`ifdef PIPE_STAGE_SKID_EN
            skid_reg <= skid_next;
`endif
        end
    end

    // Saturating back-pressure counter; deliberately survives flush
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (valid_int && !bus.ready_i && !flush_i && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table, hand-written corner sequences and an
// in-order scoreboard on every handshake; adapts to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID_EN = 1'b1;
`else
    localparam bit SKID_EN = 1'b0;
`endif

    logic             clk_i   = 1'b0;
    logic             rst_i   = 1'b0;
    logic             flush_i = 1'b0;
    logic [CNT_W-1:0] stall_cnt_o;

    pipe_stage_reg_if #(.DATA_W(DATA_W)) bus ();

    pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus.slave),
        .flush_i     (flush_i),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks   = 0;
    int          errors   = 0;
    int          rx_count = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        r;
        logic        f;
        logic        ev;
        logic        er;
        logic [63:0] ed;
        logic [3:0]  es;
    } vec_t;
    vec_t tbl[12];

    localparam logic [63:0] PA = 64'h0000_0004_0000_0013;
    localparam logic [63:0] PB = 64'h0000_0008_0000_0093;
    localparam logic [63:0] PC = 64'h0000_000C_0000_0113;
    localparam logic [63:0] PD = 64'h0000_0010_0000_0193;
    localparam logic [63:0] PE = 64'h0000_0014_0000_0213;
    localparam logic [63:0] PF = 64'h0000_0018_0000_0293;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic r, input logic f);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.ready_i = r;
        flush_i     = f;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: accepted inputs queued, every output handshake must match the head
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (bus.valid_o && bus.ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_extra: got %h expected no output", bus.data_o);
                    end else begin
                        chk("sb_data", bus.data_o, exp_q.pop_front());
                    end
                    rx_count++;
                end
                if (bus.valid_i && bus.ready_o) exp_q.push_back(bus.data_i);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] pl[8];
        int          k;
        int          cyc;
        logic        acc;

        drive(1'b0, 64'h0, 1'b0, 1'b0);
        //      v    d     r    f    ev            er            ed                es
        tbl[0]  = '{1'b1, PA, 1'b1, 1'b0, 1'b1,  1'b1,         PA,               4'd0};
        tbl[1]  = '{1'b1, PB, 1'b1, 1'b0, 1'b1,  1'b1,         PB,               4'd0};
        tbl[2]  = '{1'b0, 0,  1'b1, 1'b0, 1'b0,  1'b1,         PB,               4'd0};
        tbl[3]  = '{1'b0, 0,  1'b0, 1'b0, 1'b0,  1'b1,         PB,               4'd0};
        tbl[4]  = '{1'b1, PC, 1'b0, 1'b0, 1'b1,  SKID_EN,      PC,               4'd0};
        tbl[5]  = '{1'b1, PD, 1'b0, 1'b0, 1'b1,  1'b0,         PC,               4'd1};
        tbl[6]  = '{1'b0, 0,  1'b1, 1'b0, SKID_EN, 1'b1,       SKID_EN ? PD : PC, 4'd1};
        tbl[7]  = '{1'b0, 0,  1'b1, 1'b0, 1'b0,  1'b1,         SKID_EN ? PD : PC, 4'd1};
        tbl[8]  = '{1'b1, PE, 1'b1, 1'b1, 1'b0,  1'b1,         64'h0,            4'd1};
        tbl[9]  = '{1'b1, PF, 1'b1, 1'b0, 1'b1,  1'b1,         PF,               4'd1};
        tbl[10] = '{1'b0, 0,  1'b0, 1'b1, 1'b0,  1'b1,         64'h0,            4'd1};
        tbl[11] = '{1'b0, 0,  1'b1, 1'b0, 1'b0,  1'b1,         64'h0,            4'd1};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", bus.valid_o, 1'b0);
        chk("rst_ready", bus.ready_o, 1'b1);
        chk("rst_data",  bus.data_o,  64'h0);
        chk("rst_stall", stall_cnt_o, 4'd0);
        rst_i = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
            tick();
            chk($sformatf("vec%0d_valid", i), bus.valid_o, tbl[i].ev);
            chk($sformatf("vec%0d_ready", i), bus.ready_o, tbl[i].er);
            chk($sformatf("vec%0d_data", i),  bus.data_o,  tbl[i].ed);
            chk($sformatf("vec%0d_stall", i), stall_cnt_o, tbl[i].es);
        end

        // Stall counter saturation, immune to flush
        rst_i = 1'b0;
        exp_q.delete();
        tick();
        rst_i = 1'b1;
        drive(1'b1, PA, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("stall_3", stall_cnt_o, 4'd3);
        repeat (17) tick();
        chk("stall_sat", stall_cnt_o, 4'd15);
        chk("stall_hold_data", bus.data_o, PA);
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        tick();
        chk("stall_flush_cnt", stall_cnt_o, 4'd15);
        chk("stall_flush_valid", bus.valid_o, 1'b0);

        // Same-cycle ready path (combinational only without the skid buffer)
        drive(1'b1, PB, 1'b1, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        #1;
        chk("ready_comb_lo", bus.ready_o, SKID_EN);
        bus.ready_i = 1'b1;
        #1;
        chk("ready_comb_hi", bus.ready_o, 1'b1);
        tick();
        chk("ready_comb_drain", bus.valid_o, 1'b0);

        // Flush while a second word is pending: nothing may emerge later
        drive(1'b1, PA, 1'b0, 1'b0);
        tick();
        drive(1'b1, PB, 1'b0, 1'b0);
        tick();
        chk("skid_valid", bus.valid_o, 1'b1);
        chk("skid_data",  bus.data_o,  PA);
        chk("skid_ready", bus.ready_o, 1'b0);
        drive(1'b1, PC, 1'b0, 1'b1);
        tick();
        chk("flush_valid", bus.valid_o, 1'b0);
        chk("flush_data",  bus.data_o,  64'h0);
        chk("flush_ready", bus.ready_o, 1'b1);
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("flush_quiet%0d", i), bus.valid_o, 1'b0);
        end

        // Asynchronous reset between edges while holding two words
        drive(1'b1, PD, 1'b0, 1'b0);
        tick();
        drive(1'b1, PE, 1'b0, 1'b0);
        tick();
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_valid", bus.valid_o, 1'b0);
        chk("arst_data",  bus.data_o,  64'h0);
        chk("arst_ready", bus.ready_o, 1'b1);
        chk("arst_stall", stall_cnt_o, 4'd0);
        exp_q.delete();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        @(posedge clk_i);
        #3;
        rst_i    = 1'b1;
        rx_count = 0;

        // Eight-word stream under random back-pressure
        for (int i = 0; i < 8; i++) pl[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 4 + 100);
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 300) begin
            bus.valid_i = 1'b1;
            bus.data_i  = pl[k];
            bus.ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            acc = bus.ready_o;
            tick();
            if (acc) k++;
            cyc++;
        end
        chk("stream_sent", 64'(k), 64'd8);
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        cyc = 0;
        while (rx_count < 8 && cyc < 50) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        chk("stream_count", 64'(rx_count), 64'd8);
        chk("stream_left",  64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning payload width in bits (PC+4 and instruction for IF/ID).
REQ-002 The block SHALL have parameter RST_VAL, default {DATA_W{1'b0}}, meaning the payload value loaded on reset and flush (an all-zero instruction is a bubble).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-004 The block SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port valid_i  input  1  upstream payload valid.
REQ-007 The block SHALL have port data_i  input  DATA_W  upstream payload.
REQ-008 The block SHALL have port ready_o  output  1  stage can accept a payload this cycle.
REQ-009 The block SHALL have port flush_i  input  1  synchronous squash of all held and incoming payloads.
REQ-010 The block SHALL have port valid_o  output  1  downstream payload valid.
REQ-011 The block SHALL have port data_o  output  DATA_W  downstream payload.
REQ-012 The block SHALL have port ready_i  input  1  downstream accepts the payload this cycle.
REQ-013 The block SHALL have port stall_cnt_o  output  CNT_W  count of back-pressure cycles.

Function
REQ-014 A transfer SHALL occur on an input edge when valid_i=1 and ready_o=1, and on an output edge when valid_o=1 and ready_i=1.
REQ-015 The block SHALL implement states EMPTY (no payload), FULL (main register valid) and SKID (main and skid registers both valid); valid_o SHALL be 1 in FULL and SKID.
REQ-016 ready_o SHALL be driven only from the state register: it is 0 in SKID and 1 otherwise, with no combinational path from ready_i.
REQ-017 From EMPTY, an input transfer SHALL load the main register and move to FULL; otherwise the block SHALL stay in EMPTY.
REQ-018 From FULL with an output transfer and an input transfer on the same edge, the block SHALL load data_i into the main register and stay in FULL.
REQ-019 From FULL with an output transfer and no input transfer, the block SHALL move to EMPTY.
REQ-020 From FULL with an input transfer and ready_i=0, the block SHALL write data_i to the skid register and move to SKID, leaving data_o unchanged.
REQ-021 From SKID with ready_i=1, the block SHALL copy the skid register into the main register and move to FULL; otherwise it SHALL hold.
REQ-022 Payload latency SHALL be 1 cycle when the stage is empty or draining, and payload order SHALL be preserved.
REQ-023 flush_i=1 SHALL take priority over all other inputs on the same edge: the next state SHALL be EMPTY, data_o SHALL become RST_VAL, and any same-cycle input SHALL be dropped.
REQ-024 In EMPTY without a flush, data_o SHALL hold its last value.
REQ-025 stall_cnt_o SHALL increment on every edge where valid_o=1, ready_i=0 and flush_i=0.
REQ-026 stall_cnt_o SHALL saturate at 2^CNT_W-1, SHALL NOT wrap, and SHALL NOT be cleared by flush.

Reset
REQ-027 While rst_i=0, asynchronously: state SHALL be EMPTY, valid_o 0, ready_o 1, data_o RST_VAL, skid register RST_VAL, stall_cnt_o 0.
REQ-028 Reset asserted mid-transfer SHALL discard all held payloads; the first edge after release SHALL behave as from EMPTY.

Configuration
REQ-029 With macro PIPE_STAGE_SKID_EN defined, the block SHALL implement the three-state skid behaviour of REQ-015 to REQ-021.
REQ-030 With PIPE_STAGE_SKID_EN undefined, the block SHALL omit the SKID state and skid register and SHALL drive ready_o = ready_i | ~valid_o combinationally (a plain stall/flush register); REQ-023 to REQ-028 SHALL still apply.

Verification (DATA_W=64, CNT_W=4, SKID_EN defined)
REQ-031 Reset, then drive valid_i=1 with data 0x0000_0004_0000_0013 and hold ready_i=1 -> valid_o=1 one edge later with the same data; ready_o stays 1.
REQ-032 In FULL holding A, drive ready_i=0 and input B -> state SKID, data_o=A, ready_o=0; then ready_i=1 -> A accepted and data_o=B; next edge -> EMPTY.
REQ-033 In SKID, assert flush_i together with valid_i=1 -> next edge valid_o=0, data_o=0, ready_o=1; input dropped; no later emission of A or B.
REQ-034 Hold valid_o=1 and ready_i=0 for 20 cycles -> stall_cnt_o reaches 15 and stays 15; a following flush leaves it 15.
REQ-035 Drop rst_i asynchronously between edges while in SKID -> outputs take reset values immediately; a stream of 8 payloads after release arrives in order with no duplicates or losses.
REQ-036 Rebuild without SKID_EN and drive ready_i=0 with valid_o=1 -> ready_o=0 in the same cycle; raising ready_i -> ready_o=1 in the same cycle.
